instr_fetch_unit: RTL and testbench

// - Fetch stage that feeds the controller. Holds the PC, fetches instructions over a req/valid

---
 rtl/instr_fetch_unit_pkg.sv | 18 +
 rtl/instr_fetch_unit_if.sv | 23 ++
 rtl/instr_fetch_unit_next_pc_calc.sv | 41 ++++
 rtl/instr_fetch_unit.sv | 95 +++++++++
 tb/tb_instr_fetch_unit.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the fetch stage: decoded opcode/funct values and FSM state encoding.
package instr_fetch_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    typedef enum logic [1:0] {
        StRst   = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2
    } state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read channel: the fetch unit is master, the memory is slave.
interface instr_fetch_unit_if;

    logic        im_req;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        im_valid;

    modport master (
        output im_req,
        output im_addr,
        input  im_rdata,
        input  im_valid
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_rdata,
        output im_valid
    );

endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Combinational next-PC resolution for sequential flow, beq/bne, j/jal and jr/jalr.
module instr_fetch_unit_next_pc_calc
    import instr_fetch_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        alu_zero_i,
    input  logic [31:0] rs_data_i,
    output logic [31:0] next_pc_o,
    output logic        misalign_hit_o
);

    logic [31:0] p4;
    logic [31:0] br_target;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    assign p4        = pc_i + 32'd4;
    assign br_target = p4 + {{14{instr_i[15]}}, instr_i[15:0], 2'b00};
    assign opcode    = instr_i[31:26];
    assign funct     = instr_i[5:0];

    always_comb begin
        next_pc_o      = p4;
        misalign_hit_o = 1'b0;
        case (opcode)
            OP_BEQ:       next_pc_o = alu_zero_i ? br_target : p4;
            OP_BNE:       next_pc_o = alu_zero_i ? p4 : br_target;
            OP_J, OP_JAL: next_pc_o = {p4[31:28], instr_i[25:0], 2'b00};
            OP_RTYPE: begin
                if (funct == FN_JR || funct == FN_JALR) begin
                    // Low bits are dropped; a non-zero pair is flagged rather than trapped.
                    next_pc_o      = {rs_data_i[31:2], 2'b00};
                    misalign_hit_o = |rs_data_i[1:0];
                end
            end
            default: next_pc_o = p4;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches over the req/valid channel, holds the instruction until
// commit, then advances to the resolved next PC and counts the retirement.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    instr_fetch_unit_if.master   im,
    output logic [31:0]          instr_o,
    output logic [5:0]           opcode_o,
    output logic [5:0]           funct_o,
    output logic                 instr_valid_o,
    input  logic                 commit_i,
    input  logic                 alu_zero_i,
    input  logic [31:0]          rs_data_i,
    output logic [31:0]          pc_o,
    output logic [31:0]          link_addr_o,
    output logic                 misalign_o,
    output logic [CNT_W-1:0]     retired_o
);

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [31:0]      next_pc;
    logic             misalign_hit;

    instr_fetch_unit_next_pc_calc u_next_pc_calc (
        .pc_i           (pc_q),
        .instr_i        (instr_q),
        .alu_zero_i     (alu_zero_i),
        .rs_data_i      (rs_data_i),
        .next_pc_o      (next_pc),
        .misalign_hit_o (misalign_hit)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        misalign_d = misalign_q;
        retired_d  = retired_q;
        case (state_q)
            StRst: state_d = StFetch;
            StFetch: begin
                if (im.im_valid) begin
                    instr_d = im.im_rdata;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (commit_i) begin
                    pc_d       = next_pc;
                    retired_d  = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    misalign_d = misalign_q | misalign_hit;
                    state_d    = StFetch;
                end
            end
            default: state_d = StRst;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StRst;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            misalign_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
            retired_q  <= retired_d;
        end
    end

    assign im.im_req     = (state_q == StFetch);
    assign im.im_addr    = pc_q;
    assign instr_valid_o = (state_q == StHold);
    assign instr_o       = instr_q;
    assign opcode_o      = instr_q[31:26];
    assign funct_o       = instr_q[5:0];
    assign pc_o          = pc_q;
    assign link_addr_o   = pc_q + 32'd4;
    assign misalign_o    = misalign_q;
    assign retired_o     = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench: the driver queues the expected address/retired/misalign of each fetch and
// a negedge monitor checks every accepted fetch against it; hold-phase outputs checked inline.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit;
    logic        alu_zero;
    logic [31:0] rs_data;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        misalign;
    logic [31:0] retired;

    always #5 clk = ~clk;

    instr_fetch_unit_if im ();

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .im            (im),
        .instr_o       (instr),
        .opcode_o      (opcode),
        .funct_o       (funct),
        .instr_valid_o (instr_valid),
        .commit_i      (commit),
        .alu_zero_i    (alu_zero),
        .rs_data_i     (rs_data),
        .pc_o          (pc),
        .link_addr_o   (link_addr),
        .misalign_o    (misalign),
        .retired_o     (retired)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ret;
        logic        mis;
    } exp_t;

    exp_t        q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] ret_exp = 0;
    logic        mis_exp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted fetch must match the next queued expectation.
    always @(negedge clk) begin
        if (im.im_req && im.im_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_fetch", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("fetch_addr", im.im_addr, e.addr);
                chk("retired_at_fetch", retired, e.ret);
                chk("misalign_at_fetch", {31'd0, misalign}, {31'd0, e.mis});
            end
        end
    end

    task automatic fetch_exec(input logic [31:0] addr, input logic [31:0] ins, input int delay,
                              input int hold, input logic az, input logic [31:0] rs,
                              input logic sets_mis);
        int n = 0;
        q.push_back('{addr: addr, ret: ret_exp, mis: mis_exp});
        while (!im.im_req && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) begin
            chk("req_timeout", 32'd0, 32'd1);
            void'(q.pop_back());
            return;
        end
        for (int i = 0; i < delay; i++) begin
            im.im_valid = 1'b0;
            @(negedge clk);
            chk("req_held", {31'd0, im.im_req}, 32'd1);
            chk("no_instr_valid_in_fetch", {31'd0, instr_valid}, 32'd0);
            step();
        end
        im.im_rdata = ins;
        im.im_valid = 1'b1;
        step();
        im.im_valid = 1'b0;
        im.im_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("instr_valid_latency", {31'd0, instr_valid}, 32'd1);
        chk("instr", instr, ins);
        chk("opcode", {26'd0, opcode}, {26'd0, ins[31:26]});
        chk("funct", {26'd0, funct}, {26'd0, ins[5:0]});
        chk("pc", pc, addr);
        chk("link_addr", link_addr, addr + 32'd4);
        for (int i = 0; i < hold; i++) begin
            step();
            @(negedge clk);
            chk("hold_pc_stable", pc, addr);
            chk("hold_instr_stable", instr, ins);
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        end
        commit   = 1'b1;
        alu_zero = az;
        rs_data  = rs;
        step();
        commit   = 1'b0;
        ret_exp  = ret_exp + 32'd1;
        if (sets_mis) mis_exp = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        commit      = 1'b0;
        alu_zero    = 1'b0;
        rs_data     = '0;
        im.im_valid = 1'b0;
        im.im_rdata = '0;
        step();
        step();
        @(negedge clk);
        chk("rst_im_req", {31'd0, im.im_req}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        rst = 1'b0;

        //          addr          instr         dly hold az    rs_data       mis
        fetch_exec(32'h0000_0000, 32'h0800_0004, 0, 0, 1'b0, 32'h0,        1'b0); // j 0x10
        fetch_exec(32'h0000_0010, 32'h0000_0020, 0, 0, 1'b0, 32'h0,        1'b0); // add
        fetch_exec(32'h0000_0014, 32'h0800_0008, 0, 0, 1'b0, 32'h0,        1'b0); // j 0x20
        fetch_exec(32'h0000_0020, 32'h1000_FFFE, 0, 0, 1'b1, 32'h0,        1'b0); // beq taken
        fetch_exec(32'h0000_001C, 32'h0800_0008, 0, 0, 1'b0, 32'h0,        1'b0); // j 0x20
        fetch_exec(32'h0000_0020, 32'h1000_FFFE, 0, 0, 1'b0, 32'h0,        1'b0); // beq not taken
        fetch_exec(32'h0000_0024, 32'h0800_0008, 0, 0, 1'b0, 32'h0,        1'b0); // j 0x20
        fetch_exec(32'h0000_0020, 32'h1400_FFFE, 0, 0, 1'b0, 32'h0,        1'b0); // bne taken
        fetch_exec(32'h0000_001C, 32'h0800_0008, 0, 0, 1'b0, 32'h0,        1'b0); // j 0x20
        fetch_exec(32'h0000_0020, 32'h1400_FFFE, 0, 0, 1'b1, 32'h0,        1'b0); // bne not taken
        fetch_exec(32'h0000_0024, 32'h0000_0008, 0, 0, 1'b0, 32'hF000_0000, 1'b0); // jr
        fetch_exec(32'hF000_0000, 32'h0C00_0100, 5, 3, 1'b0, 32'h0,        1'b0); // jal, slow
        fetch_exec(32'hF000_0400, 32'h0000_0009, 0, 0, 1'b0, 32'h0000_0203, 1'b1); // jalr misaligned
        fetch_exec(32'h0000_0200, 32'h0000_0020, 0, 1, 1'b0, 32'h0,        1'b0); // add

        // Abandon the fetch at 0x204 with reset; a late im_valid must be ignored.
        @(negedge clk);
        chk("sticky_misalign", {31'd0, misalign}, 32'd1);
        chk("abandon_addr", im.im_addr, 32'h0000_0204);
        rst = 1'b1;
        step();
        rst         = 1'b0;
        im.im_rdata = 32'hDEAD_BEEF;
        im.im_valid = 1'b1;
        @(negedge clk);
        chk("abandon_req_dropped", {31'd0, im.im_req}, 32'd0);
        chk("abandon_pc", pc, 32'h0);
        chk("abandon_retired", retired, 32'h0);
        chk("abandon_misalign_cleared", {31'd0, misalign}, 32'd0);
        step();
        im.im_valid = 1'b0;
        @(negedge clk);
        chk("late_valid_ignored", {31'd0, instr_valid}, 32'd0);
        chk("refetch_req", {31'd0, im.im_req}, 32'd1);
        ret_exp = 0;
        mis_exp = 1'b0;

        // Reset together with commit: reset wins.
        q.push_back('{addr: 32'h0, ret: 32'h0, mis: 1'b0});
        im.im_rdata = 32'h0000_0020;
        im.im_valid = 1'b1;
        step();
        im.im_valid = 1'b0;
        @(negedge clk);
        chk("rc_instr_valid", {31'd0, instr_valid}, 32'd1);
        commit = 1'b1;
        rst    = 1'b1;
        step();
        commit = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        chk("rc_pc", pc, 32'h0);
        chk("rc_retired", retired, 32'h0);
        chk("rc_instr_valid_low", {31'd0, instr_valid}, 32'd0);
        chk("rc_instr_cleared", instr, 32'h0);
        chk("queue_drained", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
